// File: rtl/rf_ctrl_pkg.sv
// Shared register-file control types: architectural widths and write-source encoding.
package rf_ctrl_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREGS  = 32;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_CORE,
        SRC_MDU,
        SRC_DBG
    } src_e;

endpackage

// File: rtl/rf_wport_arbiter_if.sv
// Write-source handshakes and the register bank write port, bundled between sources and arbiter.
interface rf_wport_if;
    import rf_ctrl_pkg::*;

    logic              core_we;
    logic [REG_AW-1:0] core_rd;
    logic [XLEN-1:0]   core_data;

    logic              mdu_valid;
    logic [REG_AW-1:0] mdu_rd;
    logic [XLEN-1:0]   mdu_data;
    logic              mdu_ready;

    logic              dbg_valid;
    logic [REG_AW-1:0] dbg_rd;
    logic [XLEN-1:0]   dbg_data;
    logic              dbg_ready;

    logic              regWrite;
    logic [REG_AW-1:0] writePort;
    logic [XLEN-1:0]   wBus;

    // Source side: drives requests, observes acceptance and the bank port.
    modport master (
        output core_we, core_rd, core_data,
        output mdu_valid, mdu_rd, mdu_data,
        output dbg_valid, dbg_rd, dbg_data,
        input  mdu_ready, dbg_ready,
        input  regWrite, writePort, wBus
    );

    modport slave (
        input  core_we, core_rd, core_data,
        input  mdu_valid, mdu_rd, mdu_data,
        input  dbg_valid, dbg_rd, dbg_data,
        output mdu_ready, dbg_ready,
        output regWrite, writePort, wBus
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Busy scoreboard for registers awaiting an MDU result, with two decode-stage query ports.
module rf_scoreboard
    import rf_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic              clr_valid,
    input  logic [REG_AW-1:0] clr_rd,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              busy_err
);

    localparam logic [NREGS-1:0] X0_MASK = {{(NREGS-1){1'b1}}, 1'b0};

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;
    logic             set_valid;

    assign set_valid = issue_valid && (issue_rd != '0);

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_valid) set_mask[issue_rd] = 1'b1;
        if (clr_valid) clr_mask[clr_rd]   = 1'b1;
    end

    // Set is applied after clear so a same-cycle issue keeps the register busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_err <= 1'b0;
        end else begin
            busy <= ((busy & ~clr_mask) | set_mask) & X0_MASK;
            if (set_valid && busy[issue_rd] && !clr_mask[issue_rd])
                busy_err <= 1'b1;
        end
    end

    // Queries see the registered vector only; a clear shows up one cycle later.
    assign rs1_busy = busy[rs1];
    assign rs2_busy = busy[rs2];

endmodule

// File: rtl/rf_wport_arbiter.sv
// Single write-port arbiter: core has absolute priority, MDU and debug share round-robin.
module rf_wport_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    rf_wport_if.slave         bus,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              stall_req,
    output logic              busy_err
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    src_e              grant;
    logic              ptr_dbg;
    logic [3:0]        starve_cnt;
    logic [3:0]        starve_nxt;
    logic [REG_AW-1:0] wr_rd;
    logic [XLEN-1:0]   wr_data;
    logic              side_grant;
    logic              any_valid;

    always_comb begin
        grant = SRC_NONE;
        if (bus.core_we)
            grant = SRC_CORE;
        else if (bus.mdu_valid && (!bus.dbg_valid || !ptr_dbg))
            grant = SRC_MDU;
        else if (bus.dbg_valid)
            grant = SRC_DBG;
    end

    assign bus.mdu_ready = (grant == SRC_MDU);
    assign bus.dbg_ready = (grant == SRC_DBG);
    assign side_grant    = bus.mdu_ready || bus.dbg_ready;
    assign any_valid     = bus.mdu_valid || bus.dbg_valid;

    always_comb begin
        wr_rd   = '0;
        wr_data = '0;
        case (grant)
            SRC_CORE: begin wr_rd = bus.core_rd; wr_data = bus.core_data; end
            SRC_MDU:  begin wr_rd = bus.mdu_rd;  wr_data = bus.mdu_data;  end
            SRC_DBG:  begin wr_rd = bus.dbg_rd;  wr_data = bus.dbg_data;  end
            default:  ;
        endcase
    end

    // x0 writes are accepted but never reach the bank.
    assign bus.regWrite  = (grant != SRC_NONE) && (wr_rd != '0);
    assign bus.writePort = wr_rd;
    assign bus.wBus      = wr_data;

    always_comb begin
        starve_nxt = starve_cnt;
        if (side_grant || !any_valid)
            starve_nxt = '0;
        else if (bus.core_we)
            starve_nxt = starve_cnt + 4'd1;
    end

    // Pulse is raised on the edge where the count would reach the limit, so the
    // bubble lands in the cycle right after the last tolerated preemption.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_dbg    <= 1'b0;
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else begin
            if (side_grant)
                ptr_dbg <= bus.mdu_ready;
            if (starve_nxt == STARVE_LIM) begin
                stall_req  <= 1'b1;
                starve_cnt <= '0;
            end else begin
                stall_req  <= 1'b0;
                starve_cnt <= starve_nxt;
            end
        end
    end

    rf_scoreboard u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .clr_valid   (bus.mdu_ready),
        .clr_rd      (bus.mdu_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .busy_err    (busy_err)
    );

endmodule
